// File: rtl/event_indicator_pkg.sv
// Shared types and width helpers for the event indicator and its timer.
package event_indicator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int width_for(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/event_indicator_timer.sv
// Loadable down-counter shared by the ON and OFF phases; holds at zero.
module interval_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         en,
    output logic [W-1:0] value,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (en && value != '0) begin
            value <= value - W'(1);
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/event_indicator.sv
// Turns single-cycle events into fixed-width indicator pulses with an enforced
// off-gap, replaying events that arrive mid-pulse from a saturating backlog.
module event_indicator
    import event_indicator_pkg::*;
#(
    parameter int ON_CYCLES        = 1000,
    parameter int OFF_CYCLES       = 1000,
    parameter int MAX_PENDING      = 3,
    parameter bit OUTPUT_WHEN_IDLE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic event_in,
    output logic out,
    output logic busy,
    output logic dropped
);

    localparam int TW = width_for(max_int(ON_CYCLES, OFF_CYCLES));
    localparam int PW = $clog2(MAX_PENDING + 1);
    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

    state_t        state, next_state;
    logic          timer_load, timer_en, timer_zero;
    logic [TW-1:0] timer_load_value, timer_value;
    logic [PW-1:0] pending;
    logic          consume, pend_inc, pend_dec;

    interval_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (timer_load_value),
        .en         (timer_en),
        .value      (timer_value),
        .zero       (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state       = state;
        timer_load       = 1'b0;
        timer_load_value = ON_LOAD;
        timer_en         = 1'b0;
        consume          = 1'b0;
        pend_dec         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (event_in) begin
                    next_state = ST_ON;
                    timer_load = 1'b1;
                    consume    = 1'b1;
                end
            end
            ST_ON: begin
                if (timer_zero) begin
                    next_state       = ST_OFF;
                    timer_load       = 1'b1;
                    timer_load_value = OFF_LOAD;
                end else begin
                    timer_en = 1'b1;
                end
            end
            ST_OFF: begin
                // Backlog is served before a fresh event so ordering holds.
                if (timer_zero) begin
                    if (pending != '0) begin
                        next_state = ST_ON;
                        timer_load = 1'b1;
                        pend_dec   = 1'b1;
                    end else if (event_in) begin
                        next_state = ST_ON;
                        timer_load = 1'b1;
                        consume    = 1'b1;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end else begin
                    timer_en = 1'b1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
        pend_inc = event_in && !consume;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            out     <= OUTPUT_WHEN_IDLE;
            busy    <= 1'b0;
            dropped <= 1'b0;
        end else begin
            out     <= (next_state == ST_ON) ? ~OUTPUT_WHEN_IDLE : OUTPUT_WHEN_IDLE;
            busy    <= (next_state != ST_IDLE);
            dropped <= pend_inc && !pend_dec && (pending == PEND_MAX);
            if (pend_inc && !pend_dec && pending != PEND_MAX)
                pending <= pending + PW'(1);
            else if (pend_dec && !pend_inc)
                pending <= pending - PW'(1);
        end
    end

endmodule
